// File: rtl/write_stage_pkg.sv
// Shared widths and the writeback bundle type for the write stage.
package write_stage_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 3;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] data;
        logic [ADDR_W_DEFAULT-1:0] addr;
        logic                      we;
    } wb_bundle_t;

endpackage

// File: rtl/write_stage_wb_pipe_reg.sv
// Parameterised-width pipeline flip-flop with asynchronous active-low clear.
module wb_pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/write_stage.sv
// Writeback pipeline stage: selects ALU or memory data and registers it with
// the destination index and write enable. Option: WRITE_STAGE_ZERO_REG_GUARD_EN.
module write_stage
    import write_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic              RegStore,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] StoreMem,
    input  logic [ADDR_W-1:0] rdWB,
    output logic [DATA_W-1:0] loadData,
    output logic [ADDR_W-1:0] loadAddr,
    output logic              regWriteOut
);

    logic [DATA_W-1:0] next_data;
    logic              next_we;

    always_comb begin
        next_data = RegStore ? ALUResult : StoreMem;
`ifdef WRITE_STAGE_ZERO_REG_GUARD_EN
        // x0 is hardwired to zero, so never enable a write to it.
        next_we = RegWrite && (rdWB != '0);
`else
        next_we = RegWrite;
`endif
    end

    wb_pipe_reg #(.W(DATA_W)) data_reg (
        .clk   (clk),
        .reset (reset),
        .d     (next_data),
        .q     (loadData)
    );

    wb_pipe_reg #(.W(ADDR_W)) addr_reg (
        .clk   (clk),
        .reset (reset),
        .d     (rdWB),
        .q     (loadAddr)
    );

    wb_pipe_reg #(.W(1)) we_reg (
        .clk   (clk),
        .reset (reset),
        .d     (next_we),
        .q     (regWriteOut)
    );

endmodule

// File: tb/tb_write_stage.sv
// Table-driven bench for write_stage, plus reset and between-edge sequences.
module tb_write_stage;
    import write_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic        reg_store;
    logic [15:0] alu_result;
    logic [15:0] store_mem;
    logic [2:0]  rd_wb;
    logic [15:0] load_data;
    logic [2:0]  load_addr;
    logic        reg_write_out;

    int errors = 0;
    int checks = 0;

`ifdef WRITE_STAGE_ZERO_REG_GUARD_EN
    localparam logic X0_WE = 1'b0;
`else
    localparam logic X0_WE = 1'b1;
`endif

    typedef struct {
        logic        we_in;
        logic        store_in;
        logic [15:0] alu_in;
        logic [15:0] mem_in;
        logic [2:0]  rd_in;
        wb_bundle_t  exp;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    write_stage dut (
        .clk         (clk),
        .reset       (reset),
        .RegWrite    (reg_write),
        .RegStore    (reg_store),
        .ALUResult   (alu_result),
        .StoreMem    (store_mem),
        .rdWB        (rd_wb),
        .loadData    (load_data),
        .loadAddr    (load_addr),
        .regWriteOut (reg_write_out)
    );

    task automatic apply_stimulus(input logic we_in, input logic store_in,
                                  input logic [15:0] alu_in, input logic [15:0] mem_in,
                                  input logic [2:0] rd_in);
        reg_write  = we_in;
        reg_store  = store_in;
        alu_result = alu_in;
        store_mem  = mem_in;
        rd_wb      = rd_in;
    endtask

    task automatic check_output(input string name, input wb_bundle_t exp);
        wb_bundle_t act;
        act = '{data: load_data, addr: load_addr, we: reg_write_out};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got data=%h addr=%0d we=%b, expected data=%h addr=%0d we=%b",
                     name, act.data, act.addr, act.we, exp.data, exp.addr, exp.we);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 16'hAAAA, 16'hBBBB, 3'd5, '{16'hAAAA, 3'd5, 1'b1}};
        vecs[1] = '{1'b1, 1'b0, 16'hAAAA, 16'hBBBB, 3'd5, '{16'hBBBB, 3'd5, 1'b1}};
        vecs[2] = '{1'b0, 1'b0, 16'hAAAA, 16'hBBBB, 3'd6, '{16'hBBBB, 3'd6, 1'b0}};
        vecs[3] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 3'd7, '{16'h0000, 3'd7, 1'b1}};
        vecs[4] = '{1'b1, 1'b0, 16'h1234, 16'hFFFF, 3'd3, '{16'hFFFF, 3'd3, 1'b1}};
        vecs[5] = '{1'b0, 1'b1, 16'h8001, 16'h0000, 3'd2, '{16'h8001, 3'd2, 1'b0}};
        vecs[6] = '{1'b1, 1'b1, 16'h5A5A, 16'hA5A5, 3'd0, '{16'h5A5A, 3'd0, X0_WE}};

        // Reset asserted before any clock edge must clear outputs on its own.
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b1, 16'hAAAA, 16'hBBBB, 3'd5);
        #1 reset = 1'b0;
        #1 check_output("async_reset_no_edge", '{16'h0, 3'd0, 1'b0});
        edge_sample();
        check_output("reset_hold_edge1", '{16'h0, 3'd0, 1'b0});
        edge_sample();
        check_output("reset_hold_edge2", '{16'h0, 3'd0, 1'b0});

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].we_in, vecs[i].store_in, vecs[i].alu_in,
                           vecs[i].mem_in, vecs[i].rd_in);
            edge_sample();
            check_output($sformatf("vec%0d", i), vecs[i].exp);
        end

        // ALUResult changes between edges must not reach loadData early.
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 16'h1111, 16'h2222, 3'd4);
        edge_sample();
        check_output("hold_before_change", '{16'h1111, 3'd4, 1'b1});
        @(negedge clk);
        alu_result = 16'h3333;
        #1 check_output("hold_between_edges", '{16'h1111, 3'd4, 1'b1});
        edge_sample();
        check_output("capture_after_change", '{16'h3333, 3'd4, 1'b1});

        // Reset mid-cycle with nonzero outputs clears them before the next edge.
        @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 16'h4444, 16'hC0DE, 3'd1);
        #2 reset = 1'b0;
        #1 check_output("midcycle_reset", '{16'h0, 3'd0, 1'b0});
        edge_sample();
        check_output("midcycle_reset_hold", '{16'h0, 3'd0, 1'b0});

        // First edge after release captures normally.
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b1, 1'b1, 16'hBEEF, 16'h0F0F, 3'd2);
        edge_sample();
        check_output("first_after_release", '{16'hBEEF, 3'd2, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/write_stage.md
WRITE_STAGE -- requirements
Module: write_stage

Interface
REQ-001 Parameter DATA_W, default 16: width of ALUResult, StoreMem and loadData.
REQ-002 Parameter ADDR_W, default 3: width of rdWB and loadAddr (8-entry register file).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 RegWrite  input  1  register-file write enable from the previous pipeline stage.
REQ-006 RegStore  input  1  writeback source select: 1 = ALUResult, 0 = StoreMem.
REQ-007 ALUResult  input  DATA_W  ALU result from the previous stage.
REQ-008 StoreMem  input  DATA_W  data-memory read result from the previous stage.
REQ-009 rdWB  input  ADDR_W  destination register index.
REQ-010 loadData  output  DATA_W  registered write data to the register file.
REQ-011 loadAddr  output  ADDR_W  registered destination index to the register file.
REQ-012 regWriteOut  output  1  registered register-file write enable.

Function
REQ-013 All three outputs SHALL be driven directly from flip-flops, with no combinational path from inputs to outputs.
REQ-014 At each rising clk edge with reset deasserted, loadData SHALL capture ALUResult when RegStore=1 and StoreMem when RegStore=0.
REQ-015 At the same edge, loadAddr SHALL capture rdWB and regWriteOut SHALL capture RegWrite; latency is exactly one cycle.
REQ-016 loadData and loadAddr SHALL be captured every cycle regardless of RegWrite; consumers use regWriteOut as the sole qualifier.
REQ-017 Inputs changing between edges SHALL NOT affect the outputs until the next rising edge.
REQ-018 Data SHALL be passed bit-exact, with no arithmetic, extension or truncation.

Reset
REQ-019 When reset=0, loadData, loadAddr and regWriteOut SHALL go to 0 immediately, independent of clk.
REQ-020 Outputs SHALL hold 0 while reset=0, including across clock edges.
REQ-021 Reset asserted mid-operation SHALL discard the pending capture; no spurious regWriteOut=1 is allowed.
REQ-022 The first rising edge after reset deasserts SHALL capture the inputs normally.

Configuration
REQ-023 Macro WRITE_STAGE_ZERO_REG_GUARD_EN: when defined, regWriteOut SHALL capture 0 whenever rdWB=0, so register x0 is never written; loadData and loadAddr still capture normally.
REQ-024 When WRITE_STAGE_ZERO_REG_GUARD_EN is undefined, regWriteOut SHALL capture RegWrite unconditionally.

Structure
REQ-025 Shared package write_stage_pkg SHALL hold the DATA_W/ADDR_W defaults and a typedef for the writeback bundle (data, addr, we).
REQ-026 Sub-module wb_pipe_reg SHALL implement a parameterised-width flip-flop with asynchronous active-low clear; it is instantiated once per output field.
REQ-027 The source multiplexer and the optional zero-register guard SHALL reside in write_stage.

Verification
REQ-028 Apply reset=0 with RegWrite=1, RegStore=1, ALUResult=16'hAAAA, StoreMem=16'hBBBB, rdWB=3'b101 over clock edges -> loadData=0, loadAddr=0, regWriteOut=0.
REQ-029 Set reset=1 with the same inputs and give one rising edge -> loadData=16'hAAAA, loadAddr=3'b101, regWriteOut=1.
REQ-030 Set RegStore=0 and give one edge -> loadData=16'hBBBB; then set RegWrite=0 and give one edge -> regWriteOut=0 while loadAddr still follows rdWB.
REQ-031 Assert reset=0 mid-cycle while the outputs are nonzero -> all outputs go to 0 before the next edge.
REQ-032 With WRITE_STAGE_ZERO_REG_GUARD_EN defined, apply rdWB=0 and RegWrite=1, then give one edge -> regWriteOut=0; without the macro, the same stimulus -> regWriteOut=1.
REQ-033 Change ALUResult between edges -> loadData is unchanged until the next rising edge.
